// File: rtl/cpu_pkg.sv
// Constants and types shared by the fetch-side control blocks.
// The enum ordering gives BOOT the all-zero encoding.
package cpu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pc_ctrl_state_t;

endpackage

// File: rtl/pc_redirect_arb.sv
// Fixed-priority find-first over redirect sources, lowest index wins; blocked sources are skipped.
// Purely combinational: zero latency and no backpressure of its own.
module pc_redirect_arb #(
  parameter int XLEN  = 32,
  parameter int NSRC  = 4,
  localparam int IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic [NSRC-1:0]      valid,
  input  logic [NSRC*XLEN-1:0] target,
  input  logic [NSRC-1:0]      flush,
  input  logic [NSRC-1:0]      block,
  output logic                 win_valid,
  output logic [IDX_W-1:0]     win_idx,
  output logic [XLEN-1:0]      win_target,
  output logic                 win_flush
);

  // Scan from the youngest source down so the oldest eligible one is written last.
  always_comb begin
    win_valid  = 1'b0;
    win_idx    = '0;
    win_target = '0;
    win_flush  = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (valid[i] && !block[i]) begin
        win_valid  = 1'b1;
        win_idx    = IDX_W'(i);
        win_target = target[i*XLEN +: XLEN];
        win_flush  = flush[i];
      end
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC sequencer: +4 stepping or prioritised redirect, 1-cycle latency; a redirect seen while
// if_ready=0 is parked (latest wins, flushes OR'd) until accepted. Epoch tag under PC_CTRL_EPOCH_EN.
module pc_redirect_ctrl #(
  parameter int              XLEN     = cpu_pkg::XLEN,
  parameter int              NSRC     = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              EPOCH_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NSRC-1:0]      src_valid,
  input  logic [NSRC*XLEN-1:0] src_target,
  input  logic [NSRC-1:0]      src_flush,
  input  logic [NSRC-1:0]      src_block,
  input  logic                 if_ready,
  output logic [XLEN-1:0]      target,
  output logic                 target_valid,
  output logic                 flush
`ifdef PC_CTRL_EPOCH_EN
  ,
  output logic [EPOCH_W-1:0]   epoch
`endif
);

  import cpu_pkg::*;

  localparam int              IDX_W      = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  pc_ctrl_state_t  state, state_n;
  logic [XLEN-1:0] target_n;
  logic            flush_n;
  logic [XLEN-1:0] pend_target, pend_target_n;
  logic            pend_flush, pend_flush_n;

  logic             win_valid;
  logic [IDX_W-1:0] win_idx;
  logic [XLEN-1:0]  win_target;
  logic             win_flush;
  logic [XLEN-1:0]  win_aligned;
  logic             unused_win_idx;

  pc_redirect_arb #(
    .XLEN (XLEN),
    .NSRC (NSRC)
  ) u_arb (
    .valid      (src_valid),
    .target     (src_target),
    .flush      (src_flush),
    .block      (src_block),
    .win_valid  (win_valid),
    .win_idx    (win_idx),
    .win_target (win_target),
    .win_flush  (win_flush)
  );

  assign unused_win_idx = ^win_idx;
  assign win_aligned    = win_target & ALIGN_MASK;
  assign target_valid   = (state != BOOT);

  always_comb begin
    state_n       = state;
    target_n      = target;
    flush_n       = 1'b0;
    pend_target_n = pend_target;
    pend_flush_n  = pend_flush;
    unique case (state)
      BOOT: state_n = RUN;
      RUN: begin
        if (win_valid) begin
          if (if_ready) begin
            target_n = win_aligned;
            flush_n  = win_flush;
          end else begin
            pend_target_n = win_aligned;
            pend_flush_n  = win_flush;
            state_n       = PEND;
          end
        end else if (if_ready) begin
          target_n = target + XLEN'(4);
        end
      end
      PEND: begin
        // A newer redirect replaces the parked address but never cancels an earlier flush.
        if (win_valid) begin
          pend_target_n = win_aligned;
          pend_flush_n  = pend_flush | win_flush;
        end
        if (if_ready) begin
          target_n      = pend_target_n;
          flush_n       = pend_flush_n;
          pend_flush_n  = 1'b0;
          state_n       = RUN;
        end
      end
      default: state_n = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= BOOT;
      target      <= RESET_PC;
      flush       <= 1'b0;
      pend_target <= '0;
      pend_flush  <= 1'b0;
    end else begin
      state       <= state_n;
      target      <= target_n;
      flush       <= flush_n;
      pend_target <= pend_target_n;
      pend_flush  <= pend_flush_n;
    end
  end

`ifdef PC_CTRL_EPOCH_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      epoch <= '0;
    end else if (flush) begin
      epoch <= epoch + EPOCH_W'(1);
    end
  end
`else
  localparam int unused_epoch_w = EPOCH_W;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed vector table, hand sequences, then random traffic vs a queue-based model.
module tb_pc_redirect_ctrl;

  localparam int          XLEN     = 32;
  localparam int          NSRC     = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NSRC-1:0]      src_valid, src_flush, src_block;
  logic [NSRC*XLEN-1:0] src_target;
  logic                 if_ready;
  logic [XLEN-1:0]      target;
  logic                 target_valid, flush;
`ifdef PC_CTRL_EPOCH_EN
  logic [1:0]           epoch;
`endif

  pc_redirect_ctrl #(
    .XLEN     (XLEN),
    .NSRC     (NSRC),
    .RESET_PC (RESET_PC),
    .EPOCH_W  (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src_valid    (src_valid),
    .src_target   (src_target),
    .src_flush    (src_flush),
    .src_block    (src_block),
    .if_ready     (if_ready),
    .target       (target),
    .target_valid (target_valid),
    .flush        (flush)
`ifdef PC_CTRL_EPOCH_EN
    ,
    .epoch        (epoch)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: redirects seen since the last accepted fetch queue up;
  // acceptance takes the newest address and the OR of all their flush bits.
  typedef struct { logic [31:0] addr; bit fl; } req_t;
  req_t        m_q[$];
  bit          m_boot;
  logic [31:0] m_tgt;
  bit          m_valid, m_flush;
  logic [1:0]  m_epoch;

  task automatic model_edge();
    bit old_flush = m_flush;
    if (!rst_n) begin
      m_boot = 1; m_tgt = RESET_PC; m_valid = 0; m_flush = 0; m_epoch = 0;
      m_q.delete();
      return;
    end
    if (old_flush) m_epoch = m_epoch + 2'd1;
    if (m_boot) begin
      m_boot = 0; m_valid = 1; m_flush = 0;
      return;
    end
    for (int i = 0; i < NSRC; i++) begin
      if (src_valid[i] && !src_block[i]) begin
        req_t r;
        r.addr = src_target[i*XLEN +: XLEN] & 32'hFFFF_FFFC;
        r.fl   = src_flush[i];
        m_q.push_back(r);
        break;
      end
    end
    m_flush = 0;
    if (if_ready) begin
      if (m_q.size() > 0) begin
        m_tgt = m_q[$].addr;
        foreach (m_q[k]) m_flush |= m_q[k].fl;
        m_q.delete();
      end else begin
        m_tgt = m_tgt + 32'd4;
      end
    end
  endtask

  task automatic step(input bit rst, input logic [3:0] v, input logic [3:0] f, input logic [3:0] b,
                      input bit rdy, input logic [127:0] tg);
    rst_n = rst; src_valid = v; src_flush = f; src_block = b; if_ready = rdy; src_target = tg;
    @(posedge clk);
    model_edge();
    #1;
    chk("mdl_target", target, m_tgt);
    chk("mdl_valid", {31'd0, target_valid}, {31'd0, m_valid});
    chk("mdl_flush", {31'd0, flush}, {31'd0, m_flush});
`ifdef PC_CTRL_EPOCH_EN
    chk("mdl_epoch", {30'd0, epoch}, {30'd0, m_epoch});
`endif
  endtask

  typedef struct {
    string        name;
    bit           rst;
    logic [3:0]   v, f, b;
    bit           rdy;
    logic [127:0] tg;
    logic [31:0]  e_tgt;
    bit           e_vld, e_fl;
  } vec_t;

  function automatic vec_t mk(input string n, input bit rst, input logic [3:0] v, input logic [3:0] f,
                              input logic [3:0] b, input bit rdy, input logic [31:0] t0, input logic [31:0] t1,
                              input logic [31:0] t2, input logic [31:0] t3,
                              input logic [31:0] et, input bit ev, input bit ef);
    vec_t x;
    x.name = n; x.rst = rst; x.v = v; x.f = f; x.b = b; x.rdy = rdy;
    x.tg = {t3, t2, t1, t0}; x.e_tgt = et; x.e_vld = ev; x.e_fl = ef;
    return x;
  endfunction

  vec_t vecs[$];

  initial begin
    rst_n = 0; src_valid = 0; src_flush = 0; src_block = 0; if_ready = 0; src_target = '0;
    m_boot = 1; m_tgt = RESET_PC; m_valid = 0; m_flush = 0; m_epoch = 0;

    vecs.push_back(mk("reset",        0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 0,                 32'h0,        0, 0));
    vecs.push_back(mk("boot",         1, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 0,                 32'h0,        1, 0));
    vecs.push_back(mk("seq4",         1, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 0,                 32'h4,        1, 0));
    vecs.push_back(mk("seq8",         1, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 0,                 32'h8,        1, 0));
    vecs.push_back(mk("prio_flush",   1, 4'b0011, 4'b0001, 4'b0000, 1, 32'h100, 32'h200, 0, 0,     32'h100,      1, 1));
    vecs.push_back(mk("after_redir",  1, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 0,                 32'h104,      1, 0));
    vecs.push_back(mk("blocked_src0", 1, 4'b0101, 4'b0001, 4'b0001, 1, 32'h900, 0, 32'h300, 0,     32'h300,      1, 0));
    vecs.push_back(mk("pend_enter",   1, 4'b0001, 4'b0001, 4'b0000, 0, 32'h400, 0, 0, 0,           32'h300,      1, 0));
    vecs.push_back(mk("pend_over",    1, 4'b0010, 4'b0000, 4'b0000, 0, 0, 32'h500, 0, 0,           32'h300,      1, 0));
    vecs.push_back(mk("pend_apply",   1, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 0,                 32'h500,      1, 1));
    vecs.push_back(mk("back_in_run",  1, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 0,                 32'h504,      1, 0));
    vecs.push_back(mk("to_top",       1, 4'b0001, 4'b0000, 4'b0000, 1, 32'hFFFF_FFFC, 0, 0, 0,     32'hFFFF_FFFC, 1, 0));
    vecs.push_back(mk("wrap",         1, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 0,                 32'h0,        1, 0));
    vecs.push_back(mk("align",        1, 4'b1000, 4'b1000, 4'b0000, 1, 0, 0, 0, 32'h1003,          32'h1000,     1, 1));
    vecs.push_back(mk("hold",         1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0,                 32'h1000,     1, 0));
    vecs.push_back(mk("pend_fl",      1, 4'b0001, 4'b0001, 4'b0000, 0, 32'h2000, 0, 0, 0,          32'h1000,     1, 0));
    vecs.push_back(mk("pend_new_win", 1, 4'b0100, 4'b0000, 4'b0000, 1, 0, 0, 32'h2222, 0,          32'h2220,     1, 1));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].v, vecs[i].f, vecs[i].b, vecs[i].rdy, vecs[i].tg);
      chk({vecs[i].name, "_tgt"}, target, vecs[i].e_tgt);
      chk({vecs[i].name, "_vld"}, {31'd0, target_valid}, {31'd0, vecs[i].e_vld});
      chk({vecs[i].name, "_fl"},  {31'd0, flush}, {31'd0, vecs[i].e_fl});
    end

    // Reset landing while a flushing redirect is parked: it must be forgotten.
    step(1, 4'b0001, 4'b0001, 4'b0000, 0, {96'd0, 32'h700});
    step(0, 4'b0000, 4'b0000, 4'b0000, 1, '0);
    chk("rst_pend_tgt", target, RESET_PC);
    chk("rst_pend_vld", {31'd0, target_valid}, 32'd0);
    step(1, 4'b0000, 4'b0000, 4'b0000, 1, '0);
    chk("rst_boot_tgt", target, RESET_PC);
    step(1, 4'b0000, 4'b0000, 4'b0000, 1, '0);
    chk("rst_drop_tgt", target, RESET_PC + 32'd4);
    chk("rst_drop_fl", {31'd0, flush}, 32'd0);

`ifdef PC_CTRL_EPOCH_EN
    chk("epoch_start", {30'd0, epoch}, 32'd0);
    for (int n = 1; n <= 4; n++) begin
      step(1, 4'b0001, 4'b0001, 4'b0000, 1, {96'd0, 32'h40 * n});
      step(1, 4'b0000, 4'b0000, 4'b0000, 1, '0);
      chk($sformatf("epoch_%0d", n), {30'd0, epoch}, (n == 4) ? 32'd0 : n);
    end
`endif

    for (int c = 0; c < 3000; c++) begin
      bit          r  = ($urandom_range(0, 99) != 0);
      logic [3:0]  v  = 4'($urandom);
      logic [3:0]  f  = 4'($urandom);
      logic [3:0]  b  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      bit          rd = ($urandom_range(0, 9) < 6);
      logic [127:0] tg;
      if ($urandom_range(0, 2) != 0) v = 4'b0000;
      tg = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 19) == 0) tg[31:0] = 32'hFFFF_FFFC;
      step(r, v, f, b, rd, tg);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
